// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with a runtime-programmable frame format and a
//   first-word-fall-through receive FIFO. The line is oversampled OVS times
//   per bit; each bit takes the majority of three samples around mid-bit.
//
// Ports
//   clock, reset_n          system clock, asynchronous active-low reset
//   data_tx                 serial line in (idle high, asynchronous)
//   baud_div                clocks per oversample tick minus 1
//   data_bits               00=5, 01=6, 10=7, 11=8 data bits
//   parity_type             00/11 none, 01 odd, 10 even
//   stop_bits               0 = one stop bit, 1 = two stop bits
//   rx_data/rx_perr/rx_ferr FIFO head word and its error flags (0 when empty)
//   rx_valid, rx_ready      FIFO head handshake
//   fifo_count              entries held
//   overrun, overrun_clr    sticky dropped-frame flag and its clear
//   active_flag             high while a frame is being received
//   done_flag               one-cycle pulse per completed frame
//   break_det               only with RX_BREAK_DETECT_EN: break seen, cleared
//                           by the first synchronised high level of the line
//
// Build option
//   RX_BREAK_DETECT_EN      when defined, all-zero frames are reported on
//                           break_det instead of being written to the FIFO.
module uart_rx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        data_tx,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [1:0]                  data_bits,
    input  logic [1:0]                  parity_type,
    input  logic                        stop_bits,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_perr,
    output logic                        rx_ferr,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    input  logic                        overrun_clr,
    output logic                        active_flag,
`ifdef RX_BREAK_DETECT_EN
    output logic                        break_det,
`endif
    output logic                        done_flag
);

    localparam int unsigned OW = $clog2(OVS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned WW = DATA_W + 2;
    localparam logic [OW-1:0] SMP_A = OW'(OVS/2 - 1);
    localparam logic [OW-1:0] SMP_B = OW'(OVS/2);
    localparam logic [OW-1:0] SMP_C = OW'(OVS/2 + 1);
    localparam logic [OW-1:0] LAST  = OW'(OVS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync_q;
    logic               rx_s;
    logic [DIV_W-1:0]   tick_cnt_q;
    logic               tick;
    logic [OW-1:0]      os_cnt_q, os_cnt_d;
    logic [1:0]         smp_q, smp_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic               stop2_q, stop2_d;
    logic [7:0]         data_q, data_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               armed_q, armed_d;
    logic [1:0]         cfg_bits_q, cfg_bits_d;
    logic [1:0]         cfg_par_q, cfg_par_d;
    logic               cfg_stop_q, cfg_stop_d;
    logic               start_edge, done, push, maj, at_mid, at_end;
    logic               par_en, final_stop, ferr_fin;
    logic [2:0]         last_bit;

    // Two-stage synchroniser preset high so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], data_tx};
    end
    assign rx_s = sync_q[1];

    // Tick counter is reloaded on the start edge so bit timing is edge-aligned.
    assign tick = (tick_cnt_q == '0);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 tick_cnt_q <= '0;
        else if (start_edge || tick)  tick_cnt_q <= baud_div;
        else                          tick_cnt_q <= tick_cnt_q - DIV_W'(1);
    end

    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign at_mid     = tick && (os_cnt_q == SMP_C);
    assign at_end     = tick && (os_cnt_q == LAST);
    assign par_en     = (cfg_par_q == 2'b01) || (cfg_par_q == 2'b10);
    assign last_bit   = {1'b0, cfg_bits_q} + 3'd4;
    assign final_stop = stop2_q || !cfg_stop_q;

    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        smp_d      = smp_q;
        bit_cnt_d  = bit_cnt_q;
        stop2_d    = stop2_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        armed_d    = armed_q;
        cfg_bits_d = cfg_bits_q;
        cfg_par_d  = cfg_par_q;
        cfg_stop_d = cfg_stop_q;
        start_edge = 1'b0;
        done       = 1'b0;
        ferr_fin   = ferr_q;

        if (tick && state_q != S_IDLE)
            os_cnt_d = (os_cnt_q == LAST) ? '0 : os_cnt_q + OW'(1);
        if (tick && os_cnt_q == SMP_A) smp_d[0] = rx_s;
        if (tick && os_cnt_q == SMP_B) smp_d[1] = rx_s;

        case (state_q)
            S_IDLE: begin
                if (!armed_q) begin
                    armed_d = rx_s;
                end else if (!rx_s) begin
                    start_edge = 1'b1;
                    state_d    = S_START;
                    armed_d    = 1'b0;
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    stop2_d    = 1'b0;
                    data_d     = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    cfg_bits_d = data_bits;
                    cfg_par_d  = parity_type;
                    cfg_stop_d = stop_bits;
                end
            end
            S_START: begin
                if (at_mid && maj) state_d = S_IDLE;
                else if (at_end)   state_d = S_DATA;
            end
            S_DATA: begin
                if (at_mid) data_d[bit_cnt_q] = maj;
                if (at_end) begin
                    if (bit_cnt_q == last_bit) state_d = par_en ? S_PARITY : S_STOP;
                    else                       bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PARITY: begin
                // Odd parity flags an even total, even parity an odd total.
                if (at_mid) perr_d = (^data_q) ^ maj ^ (cfg_par_q == 2'b01);
                if (at_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (at_mid) begin
                    ferr_fin = ferr_q | ~maj;
                    if (final_stop) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d = ferr_fin;
                    end
                end else if (at_end) begin
                    stop2_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            os_cnt_q   <= '0;
            smp_q      <= '0;
            bit_cnt_q  <= '0;
            stop2_q    <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            armed_q    <= 1'b0;
            cfg_bits_q <= '0;
            cfg_par_q  <= '0;
            cfg_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            smp_q      <= smp_d;
            bit_cnt_q  <= bit_cnt_d;
            stop2_q    <= stop2_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            armed_q    <= armed_d;
            cfg_bits_q <= cfg_bits_d;
            cfg_par_q  <= cfg_par_d;
            cfg_stop_q <= cfg_stop_d;
        end
    end

    assign done_flag   = done;
    assign active_flag = (state_q != S_IDLE);

`ifdef RX_BREAK_DETECT_EN
    logic one_q, is_break, brk_q;
    // Tracks any 1 among data, parity and first stop bit of the current frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        one_q <= 1'b0;
        else if (start_edge) one_q <= 1'b0;
        else if (at_mid && maj && (state_q == S_DATA || state_q == S_PARITY ||
                                   (state_q == S_STOP && !stop2_q)))
            one_q <= 1'b1;
    end
    assign is_break = !(one_q || (maj && state_q == S_STOP && !stop2_q));
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)              brk_q <= 1'b0;
        else if (done && is_break) brk_q <= 1'b1;
        else if (rx_s)             brk_q <= 1'b0;
    end
    assign break_det = brk_q;
    assign push      = done && !is_break;
`else
    assign push      = done;
`endif

    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, rptr_q, count;
    logic [WW-1:0] head, wdata;
    logic          full, pop, wr_en, drop, ovr_q;

    assign count = wptr_q - rptr_q;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = rx_valid && rx_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign wdata = {ferr_fin, perr_q, data_q[DATA_W-1:0]};

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)   rptr_q <= rptr_q + (AW+1)'(1);
            if (drop)             ovr_q <= 1'b1;
            else if (overrun_clr) ovr_q <= 1'b0;
        end
    end

    assign head       = mem_q[rptr_q[AW-1:0]];
    assign rx_valid   = (count != '0);
    assign {rx_ferr, rx_perr, rx_data} = rx_valid ? head : '0;
    assign fifo_count = count;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_tx = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  data_bits = 2'b11;
    logic [1:0]  parity_type = 2'b00;
    logic        stop_bits = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid;
    logic        rx_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        overrun;
    logic        overrun_clr = 1'b0;
    logic        active_flag, done_flag;
`ifdef RX_BREAK_DETECT_EN
    logic        break_det;
`endif

    always #5 clock = ~clock;

    uart_rx_fifo #(.DATA_W(8), .DIV_W(16), .OVS(16), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .data_tx(data_tx), .baud_div(baud_div),
        .data_bits(data_bits), .parity_type(parity_type), .stop_bits(stop_bits),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_count(fifo_count), .overrun(overrun),
        .overrun_clr(overrun_clr), .active_flag(active_flag),
`ifdef RX_BREAK_DETECT_EN
        .break_det(break_det),
`endif
        .done_flag(done_flag)
    );

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } word_t;

    word_t pend[$];
    word_t mq[$];
    bit    m_ovr = 0;
    int    n_cmp = 0, n_fail = 0, done_cnt = 0;
    int    bitclk = 64;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference FIFO: frames announced by the sender complete in order; the
    // queue holds what the FIFO must present.
    always @(negedge clock) begin : cmp
        word_t h, w;
        int    sz;
        bit    pop, drop;
        if (!reset_n) begin
            chk("rst_valid", rx_valid, 0);
            chk("rst_data", rx_data, 0);
            chk("rst_perr", rx_perr, 0);
            chk("rst_ferr", rx_ferr, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_active", active_flag, 0);
            chk("rst_done", done_flag, 0);
            pend.delete();
            mq.delete();
            m_ovr = 0;
        end else begin
            sz = mq.size();
            if (sz != 0) h = mq[0];
            else         h = '0;
            chk("valid", rx_valid, sz != 0);
            chk("count", fifo_count, sz);
            chk("data", rx_data, h.data);
            chk("perr", rx_perr, h.perr);
            chk("ferr", rx_ferr, h.ferr);
            chk("overrun", overrun, m_ovr);
            pop  = (sz != 0) && rx_ready;
            drop = 0;
            if (pop) void'(mq.pop_front());
            if (done_flag) begin
                done_cnt++;
                chk("done_expected", pend.size() != 0, 1);
                if (pend.size() != 0) begin
                    w = pend.pop_front();
                    if (sz == DEPTH && !pop) drop = 1;
                    else                     mq.push_back(w);
                end
            end
            if (drop)             m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
        end
    end

    task automatic drive_bit(input logic v);
        data_tx = v;
        repeat (bitclk) @(posedge clock);
        #1;
    endtask

    // par: 0 none, 1 odd, 2 even
    task automatic send_frame(input logic [7:0] d, input int nb, input int par,
                              input logic pbit, input logic s0, input logic s1,
                              input int ns, input logic tail);
        word_t w;
        int    ones, d0, m;
        m = (1 << nb) - 1;
        w.data = d & m[7:0];
        ones   = $countones(w.data) + int'(pbit);
        w.perr = (par == 1) ? (ones % 2 == 0) : (par == 2) ? (ones % 2 == 1) : 1'b0;
        w.ferr = (s0 == 1'b0) || (ns == 2 && s1 == 1'b0);
        data_bits   = 2'(nb - 5);
        parity_type = 2'(par);
        stop_bits   = (ns == 2);
        pend.push_back(w);
        d0 = done_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (par != 0) drive_bit(pbit);
        drive_bit(s0);
        if (ns == 2) drive_bit(s1);
        drive_bit(tail);
        chk("done_once", done_cnt - d0, 1);
    endtask

    task automatic pop1();
        @(posedge clock); #1 rx_ready = 1'b1;
        @(posedge clock); #1 rx_ready = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int d0;
        bit saw;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        // 8 data bits, odd parity, one stop
        send_frame(8'h35, 8, 1, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        @(negedge clock);
        chk("t1_data", rx_data, 8'h35);
        chk("t1_perr", rx_perr, 0);
        chk("t1_ferr", rx_ferr, 0);
        chk("t1_count", fifo_count, 1);
        pop1();

        send_frame(8'h35, 8, 1, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        @(negedge clock);
        chk("t2_data", rx_data, 8'h35);
        chk("t2_perr", rx_perr, 1);
        pop1();

        send_frame(8'h5A, 7, 2, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        @(negedge clock);
        chk("t3_data", rx_data, 8'h5A);
        chk("t3_perr", rx_perr, 0);
        pop1();

        // bad stop bit, line stays low afterwards
        send_frame(8'hC3, 8, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        saw = 0;
        for (int i = 0; i < 3 * bitclk; i++) begin
            @(negedge clock);
            if (active_flag) saw = 1;
        end
        chk("t4_ferr", rx_ferr, 1);
        chk("t4_data", rx_data, 8'hC3);
        chk("t4_no_rearm_low", saw, 0);
        @(posedge clock); #1 data_tx = 1'b1;
        repeat (bitclk) @(posedge clock);
        #1;
        pop1();

        // two stop bits
        send_frame(8'h96, 8, 0, 1'b0, 1'b1, 1'b0, 2, 1'b1);
        @(negedge clock);
        chk("t5_ferr2", rx_ferr, 1);
        pop1();
        send_frame(8'h69, 8, 2, 1'b1, 1'b1, 1'b1, 2, 1'b1);
        @(negedge clock);
        chk("t5_perr_even", rx_perr, 1);
        chk("t5_ferr_ok", rx_ferr, 0);
        pop1();

        // overrun with FIFO of 4
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        @(negedge clock);
        chk("t6_count_full", fifo_count, 4);
        chk("t6_overrun", overrun, 1);
        @(posedge clock); #1 overrun_clr = 1'b1;
        @(posedge clock); #1 overrun_clr = 1'b0;
        @(negedge clock);
        chk("t6_overrun_clr", overrun, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            chk("t6_drain", rx_data, i);
            pop1();
        end
        @(negedge clock);
        chk("t6_empty", fifo_count, 0);

        // false start: 2 tick periods low
        d0  = done_cnt;
        saw = 0;
        @(posedge clock); #1 data_tx = 1'b0;
        repeat (8) @(posedge clock);
        #1 data_tx = 1'b1;
        for (int i = 0; i < 3 * bitclk; i++) begin
            @(negedge clock);
            if (active_flag) saw = 1;
        end
        chk("t7_active_seen", saw, 1);
        chk("t7_no_done", done_cnt - d0, 0);
        chk("t7_count", fifo_count, 0);
        chk("t7_active_end", active_flag, 0);

        // tick every clock, short words
        @(posedge clock); #1 baud_div = 16'd0;
        bitclk = 16;
        repeat (bitclk) @(posedge clock);
        #1;
        send_frame(8'h2B, 6, 1, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        @(negedge clock);
        chk("t8_data6", rx_data, 8'h2B);
        pop1();
        send_frame(8'hFF, 5, 2, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        @(negedge clock);
        chk("t8_data5", rx_data, 8'h1F);
        chk("t8_perr5", rx_perr, 1);
        pop1();

        // reset in the middle of the data bits
        @(posedge clock); #1 baud_div = 16'd3;
        bitclk = 64;
        data_bits = 2'b11; parity_type = 2'b00; stop_bits = 1'b0;
        repeat (bitclk) @(posedge clock);
        #1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        reset_n = 1'b0;
        repeat (4) @(posedge clock);
        #1 data_tx = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2 * bitclk) @(posedge clock);
        #1;
        chk("t9_count", fifo_count, 0);
        chk("t9_active", active_flag, 0);
        send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        @(negedge clock);
        chk("t9_data", rx_data, 8'hA5);
        chk("t9_count1", fifo_count, 1);
        pop1();
        repeat (4) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the fixed-format UART receiver.
- Runtime-programmable baud divisor, 5–8 data bits, none/odd/even parity, 1 or 2 stop bits.
- 16x oversampling with 3-sample majority vote.
- Received words and per-word error status go into a first-word-fall-through (FWFT) FIFO, read with a valid/ready handshake.
- Sits between the serial pin and the core-side peripheral register block.

Parameters:
- DATA_W, 8: maximum data bits. data_bits selects 5..DATA_W. DATA_W must be ≥5 and ≤8.
- DIV_W, 16: width of baud_div.
- OVS, 16: oversample ticks per bit; must be even and ≥8.
- FIFO_DEPTH, 16: receive FIFO entries; must be a power of 2, ≥2.

Ports:
- clock  in  1  system clock (50 MHz nominal)
- reset_n  in  1  asynchronous active-low reset
- data_tx  in  1  serial line in, idle high, asynchronous to clock
- baud_div  in  DIV_W  clocks per oversample tick minus 1 (9600 baud @50 MHz, OVS=16 -> 325)
- data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits
- rx_data  out  DATA_W  FIFO head data; unused upper bits are 0
- rx_perr  out  1  FIFO head parity error
- rx_ferr  out  1  FIFO head framing error
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer accepts head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- overrun  out  1  sticky: a frame was dropped because the FIFO was full
- overrun_clr  in  1  clears overrun
- active_flag  out  1  high while a frame is being received
- done_flag  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset:
  - All outputs 0.
  - FIFO empty; FSM in IDLE; tick counter 0.
  - 2-FF synchroniser on data_tx presets to 1, so reset never causes a false start.
  - Reset mid-frame aborts the frame with no FIFO write.
- Tick generator:
  - Down-counter reloads baud_div and emits a 1-clock tick at 0.
  - baud_div=0 gives a tick every clock.
  - Counter restarts from baud_div on start-edge detection, so phase aligns to the edge.
- Configuration: data_bits, parity_type and stop_bits are latched on start-edge detection. Changes mid-frame take effect on the next frame.
- Sampling: each bit spans OVS ticks. The bit value is the majority of samples at ticks OVS/2-1, OVS/2 and OVS/2+1.
- FSM states:
  - IDLE:
    - Armed only after the synchronised line has been seen high.
    - A falling edge goes to START and sets active_flag=1.
  - START:
    - Majority 0 -> DATA.
    - Majority 1 -> false start: back to IDLE, active_flag=0, no done_flag, no FIFO write.
  - DATA:
    - Shift LSB first.
    - After N bits -> PARITY if parity is enabled, else STOP.
  - PARITY:
    - Odd: XOR of the data bits and the parity bit must be 1.
    - Even: that XOR must be 0.
    - Mismatch sets perr.
  - STOP:
    - Sampled bit 0 sets ferr.
    - With stop_bits=1, a second STOP bit follows; ferr is set if either stop bit is 0.
    - At the final stop-bit mid-sample, same cycle: push {ferr, perr, data}, pulse done_flag, active_flag=0, go to IDLE.
    - If the line is low, IDLE is not re-armed until the line goes high.
- FIFO:
  - Push to rx_valid latency: 1 clock.
  - Pop when rx_valid && rx_ready; next entry is visible the next clock.
  - Push while full and no pop: word dropped, overrun=1, done_flag still pulses.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overrun:
  - Cleared by overrun_clr.
  - If a set and a clear occur in the same cycle, set wins.

Optional Feature:
Macro RX_BREAK_DETECT_EN.
- Defined: adds output break_det (1 bit).
  - A break is a frame whose data bits, parity bit (if enabled) and first stop bit are all 0.
  - On a break, break_det=1 and the frame is not written to the FIFO.
  - done_flag still pulses.
  - break_det clears on the first synchronised high level of the line.
- Undefined: no port; a break frame is written as data 0 with ferr=1.

Test Plan:
- baud_div=325, 8 data bits, odd parity, 1 stop bit; send 0x35 with parity bit 1 -> rx_data=0x35, perr=0, ferr=0, done_flag pulses once, fifo_count=1.
- Same setup, send 0x35 with parity bit 0 -> rx_data=0x35, rx_perr=1; 7 data bits, even parity, send 0x5A with parity 0 -> rx_data=0x5A, rx_perr=0.
- 8 data bits, no parity, stop bit driven 0 -> rx_ferr=1 and IDLE waits for the line to go high; with 2 stop bits and the second stop bit 0 -> rx_ferr=1.
- FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 -> fifo_count=4, overrun=1; drain returns 0x01..0x04; overrun_clr -> overrun=0.
- Low glitch of 2 tick periods (~13 µs at baud_div=325) -> active_flag pulses, no done_flag, FIFO unchanged.
- Assert reset_n=0 mid-DATA -> all outputs 0, FIFO empty; next clean frame 0xA5 is received correctly.
